// File: rtl/dw_sqrt_pkg.sv
// Shared width helpers for the pipelined integer square root.
// Root width and per-stage partial-remainder width.
package dw_sqrt_pkg;

  function automatic int root_width(input int w);
    return (w + 1) / 2;
  endfunction

  // Two guard bits keep the shifted remainder from overflowing.
  function automatic int rem_width(input int rw);
    return rw + 2;
  endfunction

endpackage

// File: rtl/dw_sqrt_stage.sv
// One restoring square-root iteration: resolves a single root bit,
// then registers remainder, partial root and remaining radicand.
module dw_sqrt_stage
  import dw_sqrt_pkg::*;
#(
  parameter int RW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [RW+1:0]   rem_in,
  input  logic [RW-1:0]   root_in,
  input  logic [2*RW-1:0] rad_in,
  output logic            valid_out,
  output logic [RW+1:0]   rem_out,
  output logic [RW-1:0]   root_out,
  output logic [2*RW-1:0] rad_out
);

  localparam int REMW = rem_width(RW);

  logic [REMW-1:0] shifted;
  logic [REMW-1:0] trial;
  logic [REMW-1:0] diff;
  logic            fits;

  always_comb begin
    shifted = (rem_in << 2)
            | REMW'(rad_in[2*RW-1 -: 2]);
    trial   = (REMW'(root_in) << 2)
            | REMW'(1);
    fits    = shifted >= trial;
    diff    = shifted - trial;
  end

  // Data registers load only for a valid operand so the
  // last stage's root holds across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      root_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        rem_out  <= fits ? diff : shifted;
        root_out <= (root_in << 1) | RW'(fits);
        rad_out  <= rad_in << 2;
      end
    end
  end

endmodule

// File: rtl/dw_sqrt.sv
// Fully pipelined unsigned floor(sqrt(a)), one root bit per stage,
// MSB first; latency and stage count equal the root width.
module dw_sqrt
  import dw_sqrt_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         a,
  input  logic                     valid_in,
  output logic [(WIDTH+1)/2-1:0]   root,
  output logic                     valid_out
);

  localparam int RW   = root_width(WIDTH);
  localparam int REMW = rem_width(RW);

  logic [RW:0]     vld;
  logic [REMW-1:0] rem   [RW+1];
  logic [RW-1:0]   roots [RW+1];
  logic [2*RW-1:0] rad   [RW+1];

  // Odd widths are zero-extended on the MSB side.
  assign vld[0]   = valid_in;
  assign rem[0]   = '0;
  assign roots[0] = '0;
  assign rad[0]   = (2*RW)'(a);

  for (genvar i = 0; i < RW; i++) begin : g_stage
    dw_sqrt_stage #(
      .RW(RW)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .valid_in (vld[i]),
      .rem_in   (rem[i]),
      .root_in  (roots[i]),
      .rad_in   (rad[i]),
      .valid_out(vld[i+1]),
      .rem_out  (rem[i+1]),
      .root_out (roots[i+1]),
      .rad_out  (rad[i+1])
    );
  end

  assign root      = roots[RW];
  assign valid_out = vld[RW];

endmodule

// File: tb/tb_dw_sqrt.sv
// Directed-vector bench for dw_sqrt at WIDTH=20 (10-stage pipeline).
// Outputs are sampled on the falling edge before new inputs are driven.
module tb_dw_sqrt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [19:0] a = '0;
  logic [9:0]  root;
  logic        valid_out;

  logic        obs_v;
  logic [9:0]  obs_r;
  logic [9:0]  last_root = '0;
  logic        exp_v;
  int          compared = 0;
  int          mismatched = 0;

  dw_sqrt #(.WIDTH(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .valid_in (valid_in),
    .root     (root),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic v, input logic [19:0] x,
                      input logic r);
    @(negedge clk);
    obs_v    = valid_out;
    obs_r    = root;
    valid_in = v;
    a        = x;
    reset    = r;
  endtask

  task automatic test_reset;
    tick(1'b1, 20'd9, 1'b1);
    tick(1'b1, 20'd9, 1'b1);
    tick(1'b0, 20'd0, 1'b0);
    last_root = '0;
    compared++;
    if (obs_v !== 1'b0) begin
      mismatched++;
      $display("FAIL reset valid got %b want 0", obs_v);
    end
    compared++;
    if (obs_r !== 10'd0) begin
      mismatched++;
      $display("FAIL reset root got %0d want 0", obs_r);
    end
  endtask

  task automatic test_single;
    tick(1'b1, 20'd441, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, 20'd0, 1'b0);
      exp_v = (j == 10);
      if (exp_v) last_root = 10'd21;
      compared++;
      if (obs_v !== exp_v) begin
        mismatched++;
        $display("FAIL single valid j=%0d got %b want %b",
                 j, obs_v, exp_v);
      end
      compared++;
      if (obs_r !== last_root) begin
        mismatched++;
        $display("FAIL single root j=%0d got %0d want %0d",
                 j, obs_r, last_root);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] av [4] = '{20'd1737, 20'd5833, 20'd0, 20'd1048575};
    logic [9:0]  rv [4] = '{10'd41, 10'd76, 10'd0, 10'd1023};
    for (int j = 0; j < 16; j++) begin
      tick(j < 4, (j < 4) ? av[j & 3] : 20'd0, 1'b0);
      if (j >= 1) begin
        exp_v = (j >= 10 && j < 14);
        if (exp_v) last_root = rv[(j - 10) & 3];
        compared++;
        if (obs_v !== exp_v) begin
          mismatched++;
          $display("FAIL b2b valid j=%0d got %b want %b",
                   j, obs_v, exp_v);
        end
        compared++;
        if (obs_r !== last_root) begin
          mismatched++;
          $display("FAIL b2b root j=%0d got %0d want %0d",
                   j, obs_r, last_root);
        end
      end
    end
  endtask

  task automatic test_gap;
    logic        sv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [19:0] av [4] = '{20'd4, 20'd0, 20'd0, 20'd15};
    logic [9:0]  rv [4] = '{10'd2, 10'd0, 10'd0, 10'd3};
    for (int j = 0; j < 16; j++) begin
      tick((j < 4) ? sv[j & 3] : 1'b0,
           (j < 4) ? av[j & 3] : 20'd0, 1'b0);
      if (j >= 1) begin
        exp_v = (j >= 10 && j < 14) ? sv[(j - 10) & 3] : 1'b0;
        if (exp_v) last_root = rv[(j - 10) & 3];
        compared++;
        if (obs_v !== exp_v) begin
          mismatched++;
          $display("FAIL gap valid j=%0d got %b want %b",
                   j, obs_v, exp_v);
        end
        compared++;
        if (obs_r !== last_root) begin
          mismatched++;
          $display("FAIL gap root j=%0d got %0d want %0d",
                   j, obs_r, last_root);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 20'd100, 1'b0);
    tick(1'b0, 20'd0, 1'b0);
    tick(1'b0, 20'd0, 1'b0);
    tick(1'b1, 20'd77, 1'b1);
    tick(1'b1, 20'd77, 1'b1);
    last_root = '0;
    for (int j = 5; j <= 16; j++) begin
      tick(1'b0, 20'd0, 1'b0);
      compared++;
      if (obs_v !== 1'b0) begin
        mismatched++;
        $display("FAIL flush valid j=%0d got %b want 0", j, obs_v);
      end
      compared++;
      if (obs_r !== 10'd0) begin
        mismatched++;
        $display("FAIL flush root j=%0d got %0d want 0", j, obs_r);
      end
    end
    tick(1'b1, 20'd99, 1'b0);
    for (int j = 1; j <= 11; j++) begin
      tick(1'b0, 20'd0, 1'b0);
      exp_v = (j == 10);
      if (exp_v) last_root = 10'd9;
      compared++;
      if (obs_v !== exp_v || obs_r !== last_root) begin
        mismatched++;
        $display("FAIL after_reset j=%0d got %b/%0d want %b/%0d",
                 j, obs_v, obs_r, exp_v, last_root);
      end
    end
  endtask

  task automatic test_boundary;
    logic [19:0] av [11] = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd4,
                             20'd1048575, 20'd1046529, 20'd1046528,
                             20'd65536, 20'd65535, 20'd999999};
    logic [9:0]  rv [11] = '{10'd0, 10'd1, 10'd1, 10'd1, 10'd2,
                             10'd1023, 10'd1023, 10'd1022,
                             10'd256, 10'd255, 10'd999};
    for (int j = 0; j < 24; j++) begin
      tick(j < 11, (j < 11) ? av[j % 11] : 20'd0, 1'b0);
      if (j >= 1) begin
        exp_v = (j >= 10 && j < 21);
        if (exp_v) last_root = rv[(j - 10) % 11];
        compared++;
        if (obs_v !== exp_v || obs_r !== last_root) begin
          mismatched++;
          $display("FAIL bound j=%0d got %b/%0d want %b/%0d",
                   j, obs_v, obs_r, exp_v, last_root);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [19:0] q [$];
    logic [19:0] x;
    logic [19:0] want_a;
    logic        v;
    longint      r64;
    longint      a64;
    for (int j = 0; j < 320; j++) begin
      v = (j < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      x = 20'($urandom);
      tick(v, x, 1'b0);
      if (v) q.push_back(x);
      if (obs_v) begin
        compared++;
        if (q.size() == 0 ||
            (v && q.size() == 1)) begin
          mismatched++;
          $display("FAIL rand extra pulse j=%0d got root %0d want none",
                   j, obs_r);
        end else begin
          want_a = q.pop_front();
          a64 = longint'(want_a);
          r64 = longint'(obs_r);
          if (!(r64 * r64 <= a64 && (r64 + 1) * (r64 + 1) > a64)) begin
            mismatched++;
            $display("FAIL rand root a=%0d got %0d want isqrt(a)",
                     want_a, obs_r);
          end
        end
      end
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL rand count got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dw_sqrt.md
DW_SQRT -- requirements
Module: dw_sqrt

Interface
REQ-001 Parameter: WIDTH, 20, radicand width in bits (>= 2).
REQ-002 Derived localparam: RW, (WIDTH+1)/2, root width in bits (10 for default).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: a  input  WIDTH  unsigned radicand.
REQ-006 Port: valid_in  input  1  a is sampled as a new operand on this rising edge when high.
REQ-007 Port: root  output  RW  unsigned floor(sqrt(a)) of the associated operand.
REQ-008 Port: valid_out  output  1  root holds a fresh result this cycle.

Function
REQ-009 dw_sqrt SHALL compute root = floor(sqrt(a)), treating a as unsigned; the largest r with r*r <= a.
REQ-010 dw_sqrt SHALL be fully pipelined with RW stages, one root bit resolved per stage, MSB first (restoring digit-by-digit method).
REQ-011 Latency SHALL be exactly RW clock edges: an operand sampled at edge N with valid_in=1 yields valid_out=1 and its root after edge N+RW-1, visible until edge N+RW (10 edges for WIDTH=20).
REQ-012 Throughput SHALL be one operand per cycle; back-to-back valid_in pulses produce back-to-back valid_out pulses in order.
REQ-013 valid_out SHALL be valid_in delayed by RW cycles, with gaps preserved exactly.
REQ-014 Stages holding no valid operand SHALL NOT change root; root holds the last valid result while valid_out=0.
REQ-015 No backpressure: there is no ready signal; results are never stalled or dropped.
REQ-016 Partial-remainder arithmetic SHALL use RW+2 bits per stage so that no intermediate overflows for any a.
REQ-017 Boundary values: a=0 -> 0; a=1 -> 1; a=2^WIDTH-1 -> 2^RW-1 (1023 for WIDTH=20); perfect squares exact; k*k-1 -> k-1.
REQ-018 Odd WIDTH SHALL be handled by zero-extending a on the MSB side to 2*RW bits.

Reset
REQ-019 While reset=1 at an edge, all stage valid bits, valid_out and root SHALL become 0; valid_in is ignored on that edge.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operands; no valid_out pulse for them appears afterward.
REQ-021 First operand accepted is the one with valid_in=1 on the first edge after reset deasserts.
REQ-022 Stage data registers other than root need not be reset (valid bits gate their use).

Structure
REQ-023 No shared package is required; RW and per-stage remainder width are localparams of dw_sqrt.
REQ-024 One sub-module, dw_sqrt_stage, SHALL implement one root-bit iteration (trial subtract, select, shift) plus its pipeline register and valid bit; dw_sqrt instantiates RW of them via generate.
REQ-025 Design SHALL be synthesizable with no vendor library cells and no multipliers or dividers.

Verification
REQ-026 Reset 2 cycles, then a=441 valid 1 cycle -> exactly one valid_out pulse 10 cycles later with root=21; root=0 before it.
REQ-027 Back-to-back a=1737, 5833, 0, 1048575 -> four consecutive valid_out cycles with roots 41, 76, 0, 1023 in order.
REQ-028 Gapped stream a=4 (valid), 2 idle cycles, a=15 (valid) -> valid_out pattern 1,0,0,1 with roots 2 then 3; root holds 2 during the gap.
REQ-029 Assert reset 3 cycles after launching a=100 -> valid_out stays 0, root=0; next operand a=99 after reset -> root 9.
REQ-030 Random 10k operands over full range, random valid_in -> every root satisfies r*r <= a < (r+1)*(r+1), order and count match inputs; repeat with WIDTH=7 and WIDTH=32.
